// File: rtl/ram_pkg.sv
// Shared types and helpers for the multi-port sample/waveform RAM.
package ram_pkg;

    typedef enum logic {
        S_INIT,
        S_READY
    } state_e;

    typedef enum logic {
        RDW_OLD,
        RDW_NEW
    } rdw_mode_e;

    function automatic int bytes_per_word(input int data_size, input int byte_size);
        return data_size / byte_size;
    endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Per-port read delay line: adds STAGES register stages after the RAM read register.
module ram_read_pipe #(
    parameter int DATA_SIZE = 8,
    parameter int STAGES    = 0
) (
    input  logic                 i_clk,
    input  logic                 i_res,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_valid
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_pipe_inputs;
            assign unused_pipe_inputs = i_clk ^ i_res;
            assign out_data  = in_data;
            assign out_valid = in_valid;
        end else begin : g_stages
            logic [DATA_SIZE-1:0] data_q [STAGES];
            logic [STAGES-1:0]    valid_q;

            // Shift the valid flag every cycle; data only moves alongside a valid so the output holds between reads
            always_ff @(posedge i_clk) begin
                if (i_res) begin
                    valid_q <= '0;
                    for (int s = 0; s < STAGES; s++) begin
                        data_q[s] <= '0;
                    end
                end else begin
                    valid_q[0] <= in_valid;
                    if (in_valid) begin
                        data_q[0] <= in_data;
                    end
                    for (int s = 1; s < STAGES; s++) begin
                        valid_q[s] <= valid_q[s-1];
                        if (valid_q[s-1]) begin
                            data_q[s] <= data_q[s-1];
                        end
                    end
                end
            end

            assign out_data  = data_q[STAGES-1];
            assign out_valid = valid_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/ram_mp.sv
// Multi-port synchronous RAM with byte enables, zero-fill sweep after reset,
// lowest-port-wins write arbitration and selectable read-during-write result.
module ram_mp
    import ram_pkg::*;
#(
    parameter int ADDRESS_SIZE  = 8,
    parameter int DATA_SIZE     = 8,
    parameter int BYTE_SIZE     = 8,
    parameter int DATA_LEN      = 256,
    parameter int ACCESS_NUMBER = 2,
    parameter int READ_LATENCY  = 1,
    parameter int RDW_MODE      = 0
) (
    input  logic                                          i_clk,
    input  logic                                          i_res,
    input  logic [ADDRESS_SIZE-1:0]                       addr       [ACCESS_NUMBER-1:0],
    input  logic [DATA_SIZE-1:0]                          w_data     [ACCESS_NUMBER-1:0],
    input  logic                                          we         [ACCESS_NUMBER-1:0],
    input  logic [bytes_per_word(DATA_SIZE,BYTE_SIZE)-1:0] be         [ACCESS_NUMBER-1:0],
    input  logic                                          re         [ACCESS_NUMBER-1:0],
    output logic [DATA_SIZE-1:0]                          r_data     [ACCESS_NUMBER-1:0],
    output logic                                          r_valid    [ACCESS_NUMBER-1:0],
    output logic                                          o_ready,
    output logic                                          o_conflict [ACCESS_NUMBER-1:0],
    output logic                                          o_err      [ACCESS_NUMBER-1:0]
);

    localparam int                      BYTES      = bytes_per_word(DATA_SIZE, BYTE_SIZE);
    localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR  = ADDRESS_SIZE'(DATA_LEN - 1);
    localparam bit                      FULL_RANGE = (DATA_LEN == (1 << ADDRESS_SIZE));
    localparam bit                      NEW_DATA   = (RDW_MODE == int'(RDW_NEW));

    generate
        if (DATA_SIZE % BYTE_SIZE != 0) begin : g_bad_bytes
            $error("ram_mp: DATA_SIZE must be a multiple of BYTE_SIZE");
        end
        if (DATA_LEN > (1 << ADDRESS_SIZE)) begin : g_bad_len
            $error("ram_mp: DATA_LEN exceeds the address space");
        end
        if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
            $error("ram_mp: READ_LATENCY must be 1..3");
        end
        if (RDW_MODE < 0 || RDW_MODE > 1) begin : g_bad_rdw
            $error("ram_mp: RDW_MODE must be 0 or 1");
        end
    endgenerate

    state_e                  state;
    logic [ADDRESS_SIZE-1:0] sweep_ptr;
    logic [DATA_SIZE-1:0]    mem [0:DATA_LEN-1];

    logic                     accept;
    logic [ACCESS_NUMBER-1:0] in_range;
    logic [ACCESS_NUMBER-1:0] wr_req;
    logic [ACCESS_NUMBER-1:0] wr_lost;
    logic [ACCESS_NUMBER-1:0] wr_win;
    logic [ACCESS_NUMBER-1:0] rd_fire;
    logic [ACCESS_NUMBER-1:0] err_req;
    logic [DATA_SIZE-1:0]     rd_word [ACCESS_NUMBER];
    logic [DATA_SIZE-1:0]     s0_data [ACCESS_NUMBER];
    logic [ACCESS_NUMBER-1:0] s0_valid;

    // Requests only count on edges where the RAM was already ready and reset is not being applied
    assign accept = o_ready && !i_res;

    generate
        for (genvar p = 0; p < ACCESS_NUMBER; p++) begin : g_range
            if (FULL_RANGE) begin : g_full
                assign in_range[p] = 1'b1;
            end else begin : g_part
                localparam logic [ADDRESS_SIZE-1:0] LEN_ADDR = ADDRESS_SIZE'(DATA_LEN);
                assign in_range[p] = (addr[p] < LEN_ADDR);
            end
        end
    endgenerate

    // Classify each port's request and let the lowest-indexed writer of an address win
    always_comb begin
        wr_req  = '0;
        wr_lost = '0;
        wr_win  = '0;
        rd_fire = '0;
        err_req = '0;
        for (int p = 0; p < ACCESS_NUMBER; p++) begin
            wr_req[p]  = accept && we[p] && in_range[p];
            rd_fire[p] = accept && re[p];
            err_req[p] = accept && (we[p] || re[p]) && !in_range[p];
        end
        for (int p = 0; p < ACCESS_NUMBER; p++) begin
            for (int k = 0; k < p; k++) begin
                if (wr_req[k] && wr_req[p] && (addr[k] == addr[p])) begin
                    wr_lost[p] = 1'b1;
                end
            end
            wr_win[p] = wr_req[p] && !wr_lost[p];
        end
    end

    // Read word per port: stored word, optionally overlaid with the same-edge winning write's enabled bytes
    always_comb begin
        for (int p = 0; p < ACCESS_NUMBER; p++) begin
            rd_word[p] = '0;
            if (in_range[p]) begin
                rd_word[p] = mem[addr[p]];
                if (NEW_DATA) begin
                    for (int q = 0; q < ACCESS_NUMBER; q++) begin
                        if (wr_win[q] && (addr[q] == addr[p])) begin
                            for (int b = 0; b < BYTES; b++) begin
                                if (be[q][b]) begin
                                    rd_word[p][b*BYTE_SIZE +: BYTE_SIZE] = w_data[q][b*BYTE_SIZE +: BYTE_SIZE];
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    // Init/serve FSM: walk the sweep pointer over every word, then raise ready
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            state     <= S_INIT;
            sweep_ptr <= '0;
            o_ready   <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (sweep_ptr == LAST_ADDR) begin
                        state   <= S_READY;
                        o_ready <= 1'b1;
                    end else begin
                        sweep_ptr <= sweep_ptr + 1'b1;
                    end
                end
                S_READY: begin
                    o_ready <= 1'b1;
                end
                default: begin
                    state   <= S_INIT;
                    o_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage update: zero fill during the sweep, byte-enabled winning writes afterwards
    always_ff @(posedge i_clk) begin
        if (!i_res) begin
            if (state == S_INIT) begin
                mem[sweep_ptr] <= '0;
            end else begin
                for (int q = 0; q < ACCESS_NUMBER; q++) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (wr_win[q] && be[q][b]) begin
                            mem[addr[q]][b*BYTE_SIZE +: BYTE_SIZE] <= w_data[q][b*BYTE_SIZE +: BYTE_SIZE];
                        end
                    end
                end
            end
        end
    end

    // Status flags and first read register; data only loads on a read so it holds otherwise
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            s0_valid <= '0;
            for (int p = 0; p < ACCESS_NUMBER; p++) begin
                o_conflict[p] <= 1'b0;
                o_err[p]      <= 1'b0;
                s0_data[p]    <= '0;
            end
        end else begin
            s0_valid <= rd_fire;
            for (int p = 0; p < ACCESS_NUMBER; p++) begin
                o_conflict[p] <= wr_lost[p];
                o_err[p]      <= err_req[p];
                if (rd_fire[p]) begin
                    s0_data[p] <= rd_word[p];
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < ACCESS_NUMBER; p++) begin : g_pipe
            ram_read_pipe #(
                .DATA_SIZE (DATA_SIZE),
                .STAGES    (READ_LATENCY - 1)
            ) u_pipe (
                .i_clk     (i_clk),
                .i_res     (i_res),
                .in_data   (s0_data[p]),
                .in_valid  (s0_valid[p]),
                .out_data  (r_data[p]),
                .out_valid (r_valid[p])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ram_mp.sv
// Bench for ram_mp: two instances sharing stimulus (3-cycle latency with new-data
// read-during-write, and 1-cycle latency with old-data), checked against a word-level model.
module tb_ram_mp;

    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int BW   = 8;
    localparam int LEN  = 200;
    localparam int NP   = 3;
    localparam int NB   = DW / BW;
    localparam int RL_A = 3;
    localparam int RDW_A = 1;
    localparam int RL_B = 1;
    localparam int RDW_B = 0;

    logic          clk;
    logic          i_res;
    logic [AW-1:0] addr   [NP-1:0];
    logic [DW-1:0] w_data [NP-1:0];
    logic          we     [NP-1:0];
    logic [NB-1:0] be     [NP-1:0];
    logic          re     [NP-1:0];

    logic [DW-1:0] ra_data [NP-1:0];
    logic          ra_valid [NP-1:0];
    logic          a_ready;
    logic          a_conflict [NP-1:0];
    logic          a_err [NP-1:0];

    logic [DW-1:0] rb_data [NP-1:0];
    logic          rb_valid [NP-1:0];
    logic          b_ready;
    logic          b_conflict [NP-1:0];
    logic          b_err [NP-1:0];

    int checks   = 0;
    int failures = 0;

    ram_mp #(
        .ADDRESS_SIZE(AW), .DATA_SIZE(DW), .BYTE_SIZE(BW), .DATA_LEN(LEN),
        .ACCESS_NUMBER(NP), .READ_LATENCY(RL_A), .RDW_MODE(RDW_A)
    ) dut_a (
        .i_clk(clk), .i_res(i_res), .addr(addr), .w_data(w_data), .we(we), .be(be), .re(re),
        .r_data(ra_data), .r_valid(ra_valid), .o_ready(a_ready), .o_conflict(a_conflict), .o_err(a_err)
    );

    ram_mp #(
        .ADDRESS_SIZE(AW), .DATA_SIZE(DW), .BYTE_SIZE(BW), .DATA_LEN(LEN),
        .ACCESS_NUMBER(NP), .READ_LATENCY(RL_B), .RDW_MODE(RDW_B)
    ) dut_b (
        .i_clk(clk), .i_res(i_res), .addr(addr), .w_data(w_data), .we(we), .be(be), .re(re),
        .r_data(rb_data), .r_valid(rb_valid), .o_ready(b_ready), .o_conflict(b_conflict), .o_err(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [NP-1:0]         v;
        logic [NP-1:0][DW-1:0] d;
    } res_t;

    logic [DW-1:0] m  [LEN];
    logic [DW-1:0] nm [LEN];
    bit            taken [LEN];
    int            sweep_cnt = 0;
    bit            m_ready = 0;
    bit            started = 0;
    bit            inr;
    logic [DW-1:0] old_w, new_w;
    res_t          resA, resB, outA, outB;
    res_t          histA[$];
    res_t          histB[$];

    bit            exp_ready;
    bit            exp_conf [NP];
    bit            exp_err  [NP];
    bit            expA_valid [NP];
    bit            expB_valid [NP];
    logic [DW-1:0] expA_data [NP];
    logic [DW-1:0] expB_data [NP];

    // Word-level model: counts the sweep, then applies each edge's requests to an array
    always @(posedge clk) begin : model
        started = 1'b1;
        resA = '0;
        resB = '0;
        for (int p = 0; p < NP; p++) begin
            exp_conf[p] = 1'b0;
            exp_err[p]  = 1'b0;
        end
        if (i_res) begin
            sweep_cnt = 0;
            m_ready   = 1'b0;
            histA.delete();
            histB.delete();
            for (int p = 0; p < NP; p++) begin
                expA_data[p] = '0;
                expB_data[p] = '0;
            end
        end else if (!m_ready) begin
            sweep_cnt++;
            if (sweep_cnt == LEN) begin
                m_ready = 1'b1;
                for (int w = 0; w < LEN; w++) m[w] = '0;
            end
        end else begin
            nm = m;
            for (int w = 0; w < LEN; w++) taken[w] = 1'b0;
            for (int p = 0; p < NP; p++) begin
                inr = (int'(addr[p]) < LEN);
                if ((we[p] || re[p]) && !inr) exp_err[p] = 1'b1;
                if (we[p] && inr) begin
                    if (taken[addr[p]]) begin
                        exp_conf[p] = 1'b1;
                    end else begin
                        taken[addr[p]] = 1'b1;
                        for (int b = 0; b < NB; b++)
                            if (be[p][b]) nm[addr[p]][b*BW +: BW] = w_data[p][b*BW +: BW];
                    end
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (re[p]) begin
                    inr   = (int'(addr[p]) < LEN);
                    old_w = inr ? m[addr[p]]  : '0;
                    new_w = inr ? nm[addr[p]] : '0;
                    resA.v[p] = 1'b1;
                    resB.v[p] = 1'b1;
                    resA.d[p] = (RDW_A == 1) ? new_w : old_w;
                    resB.d[p] = (RDW_B == 1) ? new_w : old_w;
                end
            end
            m = nm;
        end
        histA.push_back(resA);
        histB.push_back(resB);
        if (histA.size() >= RL_A) begin
            outA = histA.pop_front();
            for (int p = 0; p < NP; p++) begin
                expA_valid[p] = outA.v[p];
                if (outA.v[p]) expA_data[p] = outA.d[p];
            end
        end else begin
            for (int p = 0; p < NP; p++) expA_valid[p] = 1'b0;
        end
        if (histB.size() >= RL_B) begin
            outB = histB.pop_front();
            for (int p = 0; p < NP; p++) begin
                expB_valid[p] = outB.v[p];
                if (outB.v[p]) expB_data[p] = outB.d[p];
            end
        end else begin
            for (int p = 0; p < NP; p++) expB_valid[p] = 1'b0;
        end
        exp_ready = m_ready;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output of both instances against the model, away from the rising edge
    always @(negedge clk) begin : compare
        if (started) begin
            checkOutput("ready_a", 32'(a_ready), 32'(exp_ready));
            checkOutput("ready_b", 32'(b_ready), 32'(exp_ready));
            for (int p = 0; p < NP; p++) begin
                checkOutput($sformatf("conflict_a[%0d]", p), 32'(a_conflict[p]), 32'(exp_conf[p]));
                checkOutput($sformatf("conflict_b[%0d]", p), 32'(b_conflict[p]), 32'(exp_conf[p]));
                checkOutput($sformatf("err_a[%0d]", p), 32'(a_err[p]), 32'(exp_err[p]));
                checkOutput($sformatf("err_b[%0d]", p), 32'(b_err[p]), 32'(exp_err[p]));
                checkOutput($sformatf("valid_a[%0d]", p), 32'(ra_valid[p]), 32'(expA_valid[p]));
                checkOutput($sformatf("valid_b[%0d]", p), 32'(rb_valid[p]), 32'(expB_valid[p]));
                checkOutput($sformatf("data_a[%0d]", p), 32'(ra_data[p]), 32'(expA_data[p]));
                checkOutput($sformatf("data_b[%0d]", p), 32'(rb_data[p]), 32'(expB_data[p]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        for (int p = 0; p < NP; p++) begin
            addr[p] = '0; w_data[p] = '0; we[p] = 1'b0; be[p] = '0; re[p] = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int p, input bit w, input bit r, input int a, input int d, input int b);
        addr[p]   = AW'(a);
        w_data[p] = DW'(d);
        we[p]     = w;
        re[p]     = r;
        be[p]     = NB'(b);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic waitReady(output int cycles, output int valids);
        cycles = 0;
        valids = 0;
        while (!(a_ready && b_ready) && cycles < 1000) begin
            step();
            cycles++;
            if (ra_valid[0] || rb_valid[0]) valids++;
        end
    endtask

    int cycles, valids;

    initial begin
        i_res = 1'b1;
        idle();
        step();
        step();
        checkOutput("reset_ready", 32'(a_ready), 32'h0);
        checkOutput("reset_valid", 32'(ra_valid[0]), 32'h0);
        checkOutput("reset_data", 32'(rb_data[1]), 32'h0);
        checkOutput("reset_err", 32'(a_err[2]), 32'h0);
        i_res = 1'b0;

        waitReady(cycles, valids);
        checkOutput("init_cycles", 32'(cycles), 32'd200);

        // last word reads back cleared
        applyStimulus(0, 0, 1, 199, 0, 0);
        step();
        idle();
        checkOutput("rd199_valid_b", 32'(rb_valid[0]), 32'h1);
        checkOutput("rd199_data_b", 32'(rb_data[0]), 32'h0);
        step();
        step();
        checkOutput("rd199_valid_a", 32'(ra_valid[0]), 32'h1);

        // byte enables
        applyStimulus(0, 1, 0, 5, 'hAABB, 3);
        step();
        applyStimulus(0, 1, 0, 5, 'h1122, 1);
        step();
        idle();
        applyStimulus(1, 0, 1, 5, 0, 0);
        step();
        idle();
        checkOutput("be_data_b", 32'(rb_data[1]), 32'hAA22);
        step();
        step();
        checkOutput("be_data_a", 32'(ra_data[1]), 32'hAA22);

        // same-address write conflict
        applyStimulus(0, 1, 0, 7, 'h1212, 3);
        applyStimulus(1, 1, 0, 7, 'h3434, 3);
        step();
        idle();
        checkOutput("conf_loser", 32'(a_conflict[1]), 32'h1);
        checkOutput("conf_winner", 32'(a_conflict[0]), 32'h0);
        applyStimulus(2, 0, 1, 7, 0, 0);
        step();
        idle();
        checkOutput("conf_one_cycle", 32'(a_conflict[1]), 32'h0);
        checkOutput("conf_data_b", 32'(rb_data[2]), 32'h1212);
        step();
        step();
        checkOutput("conf_data_a", 32'(ra_data[2]), 32'h1212);

        // read during write, cross port
        applyStimulus(2, 1, 0, 3, 'h5555, 3);
        step();
        applyStimulus(0, 1, 0, 3, 'h6666, 3);
        applyStimulus(1, 0, 1, 3, 0, 0);
        step();
        idle();
        checkOutput("rdw_old_b", 32'(rb_data[1]), 32'h5555);
        step();
        step();
        checkOutput("rdw_new_a", 32'(ra_data[1]), 32'h6666);

        // latency of the 3-stage instance
        applyStimulus(0, 0, 1, 10, 0, 0);
        step();
        idle();
        checkOutput("lat_e0", 32'(ra_valid[0]), 32'h0);
        step();
        checkOutput("lat_e1", 32'(ra_valid[0]), 32'h0);
        step();
        checkOutput("lat_e2", 32'(ra_valid[0]), 32'h1);
        step();
        checkOutput("lat_e3", 32'(ra_valid[0]), 32'h0);

        // out-of-range read
        applyStimulus(2, 0, 1, 250, 0, 0);
        step();
        idle();
        checkOutput("oor_err", 32'(a_err[2]), 32'h1);
        checkOutput("oor_valid_b", 32'(rb_valid[2]), 32'h1);
        checkOutput("oor_data_b", 32'(rb_data[2]), 32'h0);
        step();
        checkOutput("oor_err_drop", 32'(a_err[2]), 32'h0);
        step();
        checkOutput("oor_data_a", 32'(ra_data[2]), 32'h0);

        // reset one cycle after a read
        applyStimulus(0, 0, 1, 5, 0, 0);
        step();
        idle();
        i_res = 1'b1;
        step();
        i_res = 1'b0;
        checkOutput("mid_reset_ready", 32'(a_ready), 32'h0);
        waitReady(cycles, valids);
        checkOutput("mid_reset_valids", 32'(valids), 32'h0);
        checkOutput("mid_reset_cycles", 32'(cycles), 32'd200);

        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 9) == 0) addr[p] = AW'($urandom_range(LEN, 255));
                else                           addr[p] = AW'($urandom_range(0, 7));
                w_data[p] = DW'($urandom);
                be[p]     = NB'($urandom);
                we[p]     = ($urandom_range(0, 2) == 0);
                re[p]     = ($urandom_range(0, 1) == 1);
            end
            i_res = ($urandom_range(0, 799) == 0);
            step();
        end
        i_res = 1'b0;
        idle();
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_mp.md
# ram_mp

Parametrised multi-port synchronous RAM with byte-enable writes, configurable read latency, and selectable read-during-write behaviour. Contents are cleared by a sequential sweep after reset instead of a one-cycle clear. Same-address write conflicts and out-of-range addresses are resolved deterministically and reported on status outputs. It is the shared sample/waveform store for the signal generator's multiple access agents.

## Interface
- ADDRESS_SIZE, 8: address width per port.
- DATA_SIZE, 8: word width; must be a multiple of BYTE_SIZE.
- BYTE_SIZE, 8: write-enable granularity in bits.
- DATA_LEN, 256: number of words; must be ≤ 2**ADDRESS_SIZE (elaboration error otherwise).
- ACCESS_NUMBER, 2: number of independent ports.
- READ_LATENCY, 1: edges from request sample to data visible; legal range 1..3.
- RDW_MODE, 0: read-during-write result; 0 = old data, 1 = new data.

Ports (arrays are unpacked, indexed by port `[ACCESS_NUMBER-1:0]`):
- i_clk  in  1  sole clock, rising edge.
- i_res  in  1  reset; synchronous, active-high.
- addr  in  ADDRESS_SIZE per port  word address.
- w_data  in  DATA_SIZE per port  write data.
- we  in  1 per port  write request.
- be  in  DATA_SIZE/BYTE_SIZE per port  byte enables; write only with we=1.
- re  in  1 per port  read request.
- r_data  out  DATA_SIZE per port  read data.
- r_valid  out  1 per port  r_data carries a completed read this cycle.
- o_ready  out  1  init sweep done; requests accepted.
- o_conflict  out  1 per port  this port's write lost arbitration.
- o_err  out  1 per port  this port's request had addr ≥ DATA_LEN.

## Operation
- FSM with two states. S_INIT: clears the sweep pointer through 0..DATA_LEN-1, writing one word of zeros per edge. S_READY: serves requests. Reset forces S_INIT with pointer = 0.
- Requests are sampled only at edges where o_ready was 1 before the edge. In S_INIT, we and re are ignored and no r_valid is produced.
- Write: for each byte b with be[b]=1, mem[addr][b] <= w_data[b]; other bytes are unchanged. we with be=0 is a legal no-op.
- Conflict: if several ports write the same in-range address on the same edge, the lowest port index wins. Each losing port gets o_conflict=1 for one cycle and its write is dropped. Byte enables are not merged across ports.
- Out-of-range address (addr ≥ DATA_LEN):
  - Write is dropped.
  - Read completes with r_data=0 and r_valid=1.
  - o_err for that port is 1 for one cycle, aligned with the sample edge.
- Read-during-write: a read sampled on the same edge as a winning write to the same address returns the pre-write word when RDW_MODE=0. When RDW_MODE=1 it returns the post-write word (byte-merged). This holds for the same port and for cross-port cases.
- r_data holds its last value while r_valid=0.

## Timing
- Reset values:
  - r_data=0, r_valid=0, o_ready=0, o_conflict=0, o_err=0 for all ports.
  - State S_INIT, pointer 0, read pipeline flushed.
  - Memory contents are undefined until the sweep completes.
- Init:
  - The first edge with i_res=0 clears word 0.
  - Edge n clears word n-1.
  - At edge DATA_LEN, word DATA_LEN-1 is cleared and o_ready rises.
  - Total: DATA_LEN cycles of o_ready=0 after reset release.
- Read latency: a request sampled at edge E produces r_data/r_valid that update at edge E+READ_LATENCY-1. READ_LATENCY=1 therefore gives data immediately after the sample edge.
- Throughput: one request per port per cycle, fully pipelined.
- Writes are visible to reads sampled at the next edge, and at the same edge if RDW_MODE=1.
- o_conflict and o_err are registered and valid for the cycle after the sample edge, regardless of READ_LATENCY.
- Reset mid-operation:
  - In-flight reads are discarded (r_valid drops next edge).
  - The sweep restarts from word 0.
  - o_ready drops at the reset edge.

## Structure
- Package ram_pkg holds:
  - state_e {S_INIT, S_READY}
  - rdw_mode_e {RDW_OLD, RDW_NEW}
  - function bytes_per_word(DATA_SIZE, BYTE_SIZE)
- Sub-module ram_read_pipe (one instance per port): a READ_LATENCY-1 stage delay line for r_data/r_valid, with synchronous flush on i_res.
- Top level holds the memory array, init FSM/pointer, arbitration and RDW mux.

## Test plan
- Init sweep: assert i_res for 2 cycles, release. o_ready=0 for exactly 256 cycles and then 1. A read of addr 0xFF returns 0x00 with r_valid.
- Byte enables (DATA_SIZE=32):
  - Write 0xAABBCCDD with be=4'b1111 at addr 5.
  - Write 0x11223344 with be=4'b0101 at addr 5.
  - A read of addr 5 returns 0xAA22CC44.
- Conflict: port0 writes 0x12 and port1 writes 0x34 to addr 7 on the same edge. Port1 o_conflict=1 for one cycle. A subsequent read of addr 7 returns 0x12.
- RDW: addr 3 holds 0x55. Port0 writes 0x66 and port1 reads addr 3 on the same edge. With RDW_MODE=0 the read returns 0x55; with RDW_MODE=1 it returns 0x66.
- Latency/errors:
  - READ_LATENCY=3, DATA_LEN=200: a read of addr 10 sampled at edge E gives r_valid at edge E+2 only.
  - A read of addr 250 gives o_err=1 and r_data=0.
- Reset mid-pipeline: with READ_LATENCY=3, assert i_res one cycle after a read. No r_valid appears, and o_ready returns only after a full sweep.
